// File: rtl/axis_pkg.sv
// Shared types for the AXIS packet FIFO: the packet-mode FSM states and an
// entry-width helper so storage can be sized from the sideband parameters.
package axis_pkg;

  typedef enum logic {
    STORE   = 1'b0,
    RELEASE = 1'b1
  } pkt_state_e;

  // Width of one stored beat: tdata, tkeep, tdest, tid, tuser and tlast.
  function automatic int entry_width(input int data_w, input int dest_w,
                                     input int id_w, input int user_w);
    return data_w + data_w / 8 + dest_w + id_w + user_w + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// DEPTH x WIDTH storage array with one synchronous write port and one
// asynchronous read port; contents are deliberately not reset.
module axis_fifo_mem #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // First-word-fall-through: the head entry is visible without a read strobe.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO with full sideband, optional store-and-forward packet mode
// and cut-through release of packets too large to fit, flagged as oversize.
module axis_packet_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEST_WIDTH  = 4,
  parameter int ID_WIDTH    = 2,
  parameter int USER_WIDTH  = 4,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                      clk,
  input  logic                      resn,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic [DEST_WIDTH-1:0]     s_tdest,
  input  logic [ID_WIDTH-1:0]       s_tid,
  input  logic [USER_WIDTH-1:0]     s_tuser,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_tkeep,
  output logic [DEST_WIDTH-1:0]     m_tdest,
  output logic [ID_WIDTH-1:0]       m_tid,
  output logic [USER_WIDTH-1:0]     m_tuser,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [$clog2(DEPTH):0]    level,
  output logic [$clog2(DEPTH):0]    pkt_count,
  output logic                      oversize_err,
  input  logic                      err_clr
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int AW         = $clog2(DEPTH);
  localparam int ENTRY_W    = entry_width(DATA_WIDTH, DEST_WIDTH, ID_WIDTH, USER_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic [DEST_WIDTH-1:0] dest;
    logic [ID_WIDTH-1:0]   id;
    logic [USER_WIDTH-1:0] user;
    logic                  last;
  } entry_t;

  entry_t             wr_entry;
  entry_t             rd_entry;
  logic [ENTRY_W-1:0] rd_bits;
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               enter_release;
  pkt_state_e         state;
  pkt_state_e         state_next;

  // Pointers carry one extra wrap bit: equal low bits with differing MSBs is full.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign s_tready = !full;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  assign wr_entry = '{data: s_tdata, keep: s_tkeep, dest: s_tdest,
                      id: s_tid, user: s_tuser, last: s_tlast};
  assign rd_entry = entry_t'(rd_bits);

  axis_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_bits)
  );

  assign m_tdata = rd_entry.data;
  assign m_tkeep = rd_entry.keep;
  assign m_tdest = rd_entry.dest;
  assign m_tid   = rd_entry.id;
  assign m_tuser = rd_entry.user;
  assign m_tlast = rd_entry.last;

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state <= STORE;
    end else begin
      state <= state_next;
    end
  end

  // A FIFO that fills with no complete packet can never release in STORE,
  // so the partial packet is streamed out cut-through instead.
  always_comb begin
    state_next    = state;
    enter_release = 1'b0;
    m_tvalid      = !empty;
    if (PACKET_MODE != 0) begin
      unique case (state)
        STORE: begin
          m_tvalid = (pkt_count != '0);
          if (full && (pkt_count == '0)) begin
            state_next    = RELEASE;
            enter_release = 1'b1;
          end
        end
        RELEASE: begin
          m_tvalid = !empty;
          if (!empty && m_tready && rd_entry.last) begin
            state_next = STORE;
          end
        end
        default: state_next = STORE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      level     <= '0;
      pkt_count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      unique case ({push && s_tlast, pop && rd_entry.last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // Setting on entry to RELEASE takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      oversize_err <= 1'b0;
    end else if (enter_release) begin
      oversize_err <= 1'b1;
    end else if (err_clr) begin
      oversize_err <= 1'b0;
    end
  end

endmodule
